ac97_pcm_fifo: RTL and testbench
================================

Name: ac97_pcm_fifo

Overview:
- Stereo PCM sample buffer directly upstream of the AC-link serializer.
- Accepts 16-bit left/right sample pairs from a producer (flash streamer, APU mixer) over a valid/ready handshake.
- Releases exactly one pair per AC-link frame on ac97_strobe, as 20-bit slot 3/4 words plus slot-valid flags.
- Absorbs producer burstiness; detects and counts underruns.

Parameters:
- DEPTH, 16, number of stereo pairs stored; power of two, 4 to 256.
- HOLD_ON_UNDERRUN, 1, 1 = repeat last delivered pair on underrun; 0 = output silence (0x0000).
- AFULL_LEVEL, 12, level at or above which almost_full asserts.

Ports:
- ac97_bitclk  in  1  AC-link bit clock; the only clock.
- rst_b  in  1  asynchronous active-low reset.
- ac97_strobe  in  1  one-cycle frame strobe from the link; high on the cycle carrying bit 0.
- in_valid  in  1  producer has a pair on in_left/in_right.
- in_ready  out  1  FIFO can accept; equals !full, combinational from registered state.
- in_left  in  16  left sample, two's complement.
- in_right  in  16  right sample, two's complement.
- flush  in  1  synchronous clear of stored contents.
- clr_underrun  in  1  synchronous clear of underrun_count.
- ac97_out_slot3  out  20  left slot word.
- ac97_out_slot4  out  20  right slot word.
- ac97_out_slot3_valid  out  1  slot 3 valid tag bit.
- ac97_out_slot4_valid  out  1  slot 4 valid tag bit.
- level  out  $clog2(DEPTH)+1  current occupancy, 0 to DEPTH.
- almost_full  out  1  level >= AFULL_LEVEL.
- underrun_count  out  16  saturating count of strobes seen while empty and primed.

Behaviour:
- Reset (async assert, sync-to-clock deassert is the integrator's job): pointers = 0, level = 0, slot words = 0, slot valids = 0, primed = 0, underrun_count = 0. in_ready = 1 after reset.
- Push: in_valid && in_ready on a rising edge stores {in_left, in_right} at the write pointer. Write pointer wraps modulo DEPTH.
- Pop: ac97_strobe && !empty on a rising edge loads the head pair into the output registers.
  - Slot words update on that same edge, so they are stable from the next cycle through the whole frame. Latency is strobe edge +0, visible at the following cycle.
- Slot format: slot = {sample[15:0], 4'h0}.
- primed sets on the first successful pop. Both slot valids equal primed, so the codec sees invalid slots until real data arrives.
- Underrun: ac97_strobe while empty.
  - If primed: underrun_count increments, saturating at 0xFFFF. Slot words hold (HOLD_ON_UNDERRUN=1) or go to 0 (HOLD_ON_UNDERRUN=0). primed stays 1.
  - If not primed: no count, outputs unchanged.
- Simultaneous push and pop:
  - Not full and not empty: both occur; level unchanged.
  - Empty: the push is stored, the pop does not occur (no fall-through), and the underrun rule applies.
  - Full: in_ready = 0, so only the pop occurs; level becomes DEPTH-1.
- Flush: pointers and level go to 0 and primed clears, so slot valids drop next cycle; slot words go to 0.
  - underrun_count is preserved.
  - Flush wins over a push or pop in the same cycle.
- clr_underrun: count goes to 0. If an underrun increment hits the same cycle, clear wins.
- Occupancy tracking: level is a separate counter, not pointer difference, so full (level == DEPTH) and empty (level == 0) are unambiguous.
- No combinational path from ac97_strobe to any output.

Decomposition:
- Shared package ac97_pkg holds:
  - AC97_SLOT_W = 20 and AC97_SAMPLE_W = 16.
  - typedef stereo_sample_t {left, right}.
  - function pcm_to_slot(sample), returning {sample, 4'h0}.
- One sub-module, ac97_pcm_ram: DEPTH x 32 register array with a synchronous write port and an asynchronous read port. Pointer, level and handshake logic stay in the top.

Test Plan:
- Reset, then strobe 3 times with no pushes -> slot valids 0, slot words 0x00000, underrun_count 0.
- Push (0x1234, 0xABCD), then strobe -> next cycle slot3 = 0x12340, slot4 = 0xABCD0, both valids 1, level 0.
- DEPTH=16: push 16 pairs with no strobe -> level 16, in_ready 0, almost_full 1. A 17th in_valid is ignored. One strobe -> level 15 and in_ready 1 the next cycle.
- Primed and empty, HOLD_ON_UNDERRUN=1: strobe 3 times -> slots hold the last pair, underrun_count 3. Repeat with HOLD_ON_UNDERRUN=0 -> slots 0x00000.
- Push and strobe in the same cycle at level 0 -> count +1, level 1. At level 5 -> level stays 5 and the head pair is output.
- Level 4, flush together with a strobe -> level 0, valids 0 the next cycle, underrun_count unchanged. Also: rst_b pulsed low mid-frame -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ac97_pkg.sv
// ac97_pkg: shared AC-link PCM types and slot formatting.
package ac97_pkg;

    localparam int AC97_SLOT_W   = 20;
    localparam int AC97_SAMPLE_W = 16;

    typedef struct packed {
        logic [AC97_SAMPLE_W-1:0] left;
        logic [AC97_SAMPLE_W-1:0] right;
    } stereo_sample_t;

    // A 16-bit sample occupies the MSBs of the 20-bit slot; the low nibble is unused resolution.
    function automatic logic [AC97_SLOT_W-1:0] pcm_to_slot(input logic [AC97_SAMPLE_W-1:0] sample);
        return {sample, 4'h0};
    endfunction

endpackage

// File: rtl/ac97_pcm_ram.sv
// ac97_pcm_ram: stereo pair storage, synchronous write, asynchronous read.
module ac97_pcm_ram
    import ac97_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  stereo_sample_t           wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output stereo_sample_t           rdata_o
);

    stereo_sample_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ac97_pcm_fifo.sv
// ac97_pcm_fifo: stereo PCM buffer releasing one pair per AC-link frame strobe,
// with priming, underrun hold/silence and a saturating underrun counter.
module ac97_pcm_fifo
    import ac97_pkg::*;
#(
    parameter int DEPTH            = 16,
    parameter bit HOLD_ON_UNDERRUN = 1'b1,
    parameter int AFULL_LEVEL      = 12
) (
    input  logic                   ac97_bitclk,
    input  logic                   rst_b,
    input  logic                   ac97_strobe,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [15:0]            in_left,
    input  logic [15:0]            in_right,
    input  logic                   flush,
    input  logic                   clr_underrun,
    output logic [19:0]            ac97_out_slot3,
    output logic [19:0]            ac97_out_slot4,
    output logic                   ac97_out_slot3_valid,
    output logic                   ac97_out_slot4_valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                   almost_full,
    output logic [15:0]            underrun_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic           primed_q, primed_d;
    logic [15:0]    urun_q, urun_d;
    stereo_sample_t out_q, out_d, head;
    logic           full, empty, push, pop, urun;

    assign full  = level_q == LW'(DEPTH);
    assign empty = level_q == '0;
    assign push  = in_valid && !full && !flush;
    assign pop   = ac97_strobe && !empty && !flush;
    assign urun  = ac97_strobe && empty && primed_q && !flush;

    ac97_pcm_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (ac97_bitclk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({in_left, in_right}),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    always_comb begin
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
        level_d  = flush ? '0 : level_q + LW'(push) - LW'(pop);
        primed_d = !flush && (primed_q || pop);
        out_d    = flush ? '0 : pop ? head : (urun && !HOLD_ON_UNDERRUN) ? '0 : out_q;
        urun_d   = clr_underrun ? '0 : (urun && urun_q != 16'hFFFF) ? urun_q + 16'd1 : urun_q;
    end

    always_ff @(posedge ac97_bitclk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            primed_q <= 1'b0;
            out_q    <= '0;
            urun_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            primed_q <= primed_d;
            out_q    <= out_d;
            urun_q   <= urun_d;
        end
    end

    assign in_ready             = !full;
    assign ac97_out_slot3       = pcm_to_slot(out_q.left);
    assign ac97_out_slot4       = pcm_to_slot(out_q.right);
    assign ac97_out_slot3_valid = primed_q;
    assign ac97_out_slot4_valid = primed_q;
    assign level                = level_q;
    assign almost_full          = level_q >= LW'(AFULL_LEVEL);
    assign underrun_count       = urun_q;

endmodule

// File: tb/tb_ac97_pcm_fifo.sv
// tb_ac97_pcm_fifo: scoreboard bench driving a hold-mode and a silence-mode FIFO in lockstep.
module tb_ac97_pcm_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0, rst_b = 1'b0, strobe = 1'b0, in_valid = 1'b0, flush = 1'b0, clr = 1'b0;
    logic [15:0] in_left = '0, in_right = '0;
    logic [19:0] s3, s4, z3, z4;
    logic        v3, v4, zv3, zv4, rdy, zrdy, af, zaf;
    logic [4:0]  lvl, zlvl;
    logic [15:0] cnt, zcnt;

    int errors = 0, checks = 0;

    logic [31:0] q[$];
    logic [31:0] m_h = '0, m_z = '0;
    logic        m_p = 1'b0;
    logic [15:0] m_c = '0;

    always #5 clk = ~clk;

    ac97_pcm_fifo #(.DEPTH(DEPTH), .HOLD_ON_UNDERRUN(1'b1), .AFULL_LEVEL(12)) dut (
        .ac97_bitclk(clk), .rst_b(rst_b), .ac97_strobe(strobe), .in_valid(in_valid), .in_ready(rdy),
        .in_left(in_left), .in_right(in_right), .flush(flush), .clr_underrun(clr),
        .ac97_out_slot3(s3), .ac97_out_slot4(s4), .ac97_out_slot3_valid(v3), .ac97_out_slot4_valid(v4),
        .level(lvl), .almost_full(af), .underrun_count(cnt)
    );

    ac97_pcm_fifo #(.DEPTH(DEPTH), .HOLD_ON_UNDERRUN(1'b0), .AFULL_LEVEL(12)) dut0 (
        .ac97_bitclk(clk), .rst_b(rst_b), .ac97_strobe(strobe), .in_valid(in_valid), .in_ready(zrdy),
        .in_left(in_left), .in_right(in_right), .flush(flush), .clr_underrun(clr),
        .ac97_out_slot3(z3), .ac97_out_slot4(z4), .ac97_out_slot3_valid(zv3), .ac97_out_slot4_valid(zv4),
        .level(zlvl), .almost_full(zaf), .underrun_count(zcnt)
    );

    function automatic logic [39:0] slots(input logic [31:0] p);
        return {p[31:16], 4'h0, p[15:0], 4'h0};
    endfunction

    // Advance one clock, updating the scoreboard from the inputs presented this cycle.
    task automatic tick();
        bit full  = q.size() == DEPTH;
        bit empty = q.size() == 0;
        bit psh   = in_valid && !full;
        bit pp    = strobe && !empty;
        bit ur    = strobe && empty && m_p;
        if (flush) begin
            q.delete();
            m_p = 1'b0;
            m_h = '0;
            m_z = '0;
        end else begin
            if (pp) begin
                m_h = q.pop_front();
                m_z = m_h;
                m_p = 1'b1;
            end else if (ur) m_z = '0;
            if (psh) q.push_back({in_left, in_right});
        end
        if (clr) m_c = '0;
        else if (ur && !flush && m_c != 16'hFFFF) m_c = m_c + 16'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        in_valid = 1'b1; in_left = l; in_right = r;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic strb();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
    endtask

    task automatic model_reset();
        q.delete(); m_h = '0; m_z = '0; m_p = 1'b0; m_c = '0;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        #3;
        checks++;
        if ({s3, s4, v3, v4, lvl, cnt, rdy} !== {40'h0, 2'b00, 5'd0, 16'd0, 1'b1}) begin
            errors++; $display("FAIL reset_state: got s3=%h s4=%h v=%b%b lvl=%0d cnt=%0d rdy=%b exp zeros rdy=1", s3, s4, v3, v4, lvl, cnt, rdy);
        end
        @(posedge clk); #1;
        rst_b = 1'b1;
        model_reset();
        tick();
        checks++;
        if ({rdy, af, lvl} !== {1'b1, 1'b0, 5'd0}) begin
            errors++; $display("FAIL after_reset: got rdy=%b af=%b lvl=%0d exp 1 0 0", rdy, af, lvl);
        end
    endtask

    task automatic test_unprimed_strobe();
        repeat (3) begin strb(); tick(); end
        checks++;
        if ({s3, s4, v3, v4, cnt} !== {40'h0, 2'b00, 16'd0}) begin
            errors++; $display("FAIL unprimed_strobe: got s3=%h s4=%h v=%b%b cnt=%0d exp 0", s3, s4, v3, v4, cnt);
        end
    endtask

    task automatic test_first_pair();
        push(16'h1234, 16'hABCD);
        checks++;
        if (lvl !== 5'd1) begin errors++; $display("FAIL first_push_level: got %0d exp 1", lvl); end
        strb();
        checks++;
        if ({s3, s4, v3, v4, lvl} !== {20'h12340, 20'hABCD0, 2'b11, 5'd0}) begin
            errors++; $display("FAIL first_pop: got s3=%h s4=%h v=%b%b lvl=%0d exp 12340 abcd0 11 0", s3, s4, v3, v4, lvl);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            push(16'($urandom), 16'($urandom));
            if (i == 10) begin
                checks++;
                if (af !== 1'b0) begin errors++; $display("FAIL afull_at_11: got %b exp 0", af); end
            end
            if (i == 11) begin
                checks++;
                if (af !== 1'b1) begin errors++; $display("FAIL afull_at_12: got %b exp 1", af); end
            end
        end
        checks++;
        if ({lvl, rdy, af} !== {5'd16, 1'b0, 1'b1}) begin
            errors++; $display("FAIL full_state: got lvl=%0d rdy=%b af=%b exp 16 0 1", lvl, rdy, af);
        end
        push(16'hDEAD, 16'hBEEF);
        checks++;
        if (lvl !== 5'd16) begin errors++; $display("FAIL overflow_ignored: got lvl=%0d exp 16", lvl); end
        strb();
        checks++;
        if ({lvl, rdy, s3, s4} !== {5'd15, 1'b1, slots(m_h)}) begin
            errors++; $display("FAIL pop_from_full: got lvl=%0d rdy=%b s=%h %h exp 15 1 %h", lvl, rdy, s3, s4, slots(m_h));
        end
        while (q.size() > 0) begin
            strb();
            checks++;
            if ({s3, s4, z3, z4} !== {slots(m_h), slots(m_z)}) begin
                errors++; $display("FAIL drain_order: got %h %h / %h %h exp %h / %h", s3, s4, z3, z4, slots(m_h), slots(m_z));
            end
        end
        checks++;
        if (lvl !== 5'd0) begin errors++; $display("FAIL drained_level: got %0d exp 0", lvl); end
    endtask

    task automatic test_underrun();
        logic [39:0] last;
        last = slots(m_h);
        repeat (3) strb();
        checks++;
        if ({s3, s4, v3, v4, cnt} !== {last, 2'b11, 16'd3}) begin
            errors++; $display("FAIL underrun_hold: got s=%h %h v=%b%b cnt=%0d exp %h 11 3", s3, s4, v3, v4, cnt, last);
        end
        checks++;
        if ({z3, z4, zv3, zv4, zcnt} !== {40'h0, 2'b11, 16'd3}) begin
            errors++; $display("FAIL underrun_silence: got s=%h %h v=%b%b cnt=%0d exp 0 11 3", z3, z4, zv3, zv4, zcnt);
        end
    endtask

    task automatic test_simultaneous();
        logic [39:0] last;
        last = slots(m_h);
        in_valid = 1'b1; strobe = 1'b1; in_left = 16'h0F0F; in_right = 16'hF0F0;
        tick();
        in_valid = 1'b0; strobe = 1'b0;
        checks++;
        if ({cnt, lvl, s3, s4} !== {16'd4, 5'd1, last}) begin
            errors++; $display("FAIL push_pop_empty: got cnt=%0d lvl=%0d s=%h %h exp 4 1 %h", cnt, lvl, s3, s4, last);
        end
        for (int i = 0; i < 4; i++) push(16'(16'h100 + i), 16'(16'h200 + i));
        in_valid = 1'b1; strobe = 1'b1; in_left = 16'h5555; in_right = 16'hAAAA;
        tick();
        in_valid = 1'b0; strobe = 1'b0;
        checks++;
        if ({lvl, s3, s4} !== {5'd5, 20'h0F0F0, 20'hF0F00}) begin
            errors++; $display("FAIL push_pop_level5: got lvl=%0d s=%h %h exp 5 0f0f0 f0f00", lvl, s3, s4);
        end
        checks++;
        if (q.size() != 5 || {s3, s4} !== slots(m_h)) begin
            errors++; $display("FAIL scoreboard_sync: got %h %h exp %h", s3, s4, slots(m_h));
        end
    endtask

    task automatic test_flush();
        strb();
        flush = 1'b1; strobe = 1'b1;
        tick();
        flush = 1'b0; strobe = 1'b0;
        checks++;
        if ({lvl, v3, v4, cnt, s3, s4} !== {5'd0, 2'b00, 16'd4, 40'h0}) begin
            errors++; $display("FAIL flush: got lvl=%0d v=%b%b cnt=%0d s=%h %h exp 0 00 4 0", lvl, v3, v4, cnt, s3, s4);
        end
        push(16'h7777, 16'h8888);
        strb();
        checks++;
        if ({s3, s4, lvl, v3} !== {20'h77770, 20'h88880, 5'd0, 1'b1}) begin
            errors++; $display("FAIL after_flush: got s=%h %h lvl=%0d v=%b exp 77770 88880 0 1", s3, s4, lvl, v3);
        end
    endtask

    task automatic test_clr_underrun();
        strb();
        checks++;
        if (cnt !== 16'd5) begin errors++; $display("FAIL count_before_clr: got %0d exp 5", cnt); end
        strobe = 1'b1; clr = 1'b1;
        tick();
        strobe = 1'b0; clr = 1'b0;
        checks++;
        if ({cnt, zcnt} !== {m_c, m_c} || cnt !== 16'd0) begin
            errors++; $display("FAIL clr_wins: got cnt=%0d zcnt=%0d exp 0", cnt, zcnt);
        end
    endtask

    task automatic test_async_reset();
        push(16'h1111, 16'h2222);
        push(16'h3333, 16'h4444);
        strb();
        @(posedge clk);
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if ({s3, s4, v3, v4, lvl, cnt, rdy} !== {40'h0, 2'b00, 5'd0, 16'd0, 1'b1}) begin
            errors++; $display("FAIL async_reset: got s=%h %h v=%b%b lvl=%0d cnt=%0d rdy=%b exp 0 rdy=1", s3, s4, v3, v4, lvl, cnt, rdy);
        end
        @(posedge clk); #1;
        rst_b = 1'b1;
        model_reset();
        push(16'h4242, 16'h2424);
        strb();
        checks++;
        if ({s3, s4, v3, v4, lvl} !== {slots(m_h), 2'b11, 5'd0} || m_h !== 32'h42422424) begin
            errors++; $display("FAIL after_async_reset: got s=%h %h v=%b%b lvl=%0d exp 42420 24240 11 0", s3, s4, v3, v4, lvl);
        end
    endtask

    initial begin
        test_reset();
        test_unprimed_strobe();
        test_first_pair();
        test_full();
        test_underrun();
        test_simultaneous();
        test_flush();
        test_clr_underrun();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
